// File: rtl/nested_loop_count_if.sv
// Handshake and configuration bundle between a nested-loop index generator
// and its controller/consumer.
interface nested_loop_count_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_LEVELS = 3
);
    logic                             start;
    logic                             abort;
    logic [NUM_LEVELS*DATA_WIDTH-1:0] cfg_max;
    logic [NUM_LEVELS*DATA_WIDTH-1:0] cfg_stride;
    logic                             out_ready;
    logic                             out_valid;
    logic [NUM_LEVELS*DATA_WIDTH-1:0] count;
    logic [NUM_LEVELS-1:0]            wrap;
    logic                             last;
    logic                             busy;
    logic                             done;

    modport master (
        output start, abort, cfg_max, cfg_stride, out_ready,
        input  out_valid, count, wrap, last, busy, done
    );

    modport slave (
        input  start, abort, cfg_max, cfg_stride, out_ready,
        output out_valid, count, wrap, last, busy, done
    );
endinterface

// File: rtl/nested_loop_count.sv
// Nested-loop index generator: NUM_LEVELS cascaded counters with per-level
// max and stride, a carry chain from level 0 outward, and a valid/ready beat.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; config latched on the start cycle
//   ST_RUN  | presenting index tuples; advance on each accepted beat
//   ST_DONE | single cycle with done=1 after the final beat
module nested_loop_count #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_LEVELS = 3
) (
    input logic                clk,
    input logic                reset,
    nested_loop_count_if.slave bus
);
    localparam int W = NUM_LEVELS * DATA_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state;
    logic [W-1:0]          count_q;
    logic [W-1:0]          max_q;
    logic [W-1:0]          stride_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic [W-1:0]          count_next;
    logic [NUM_LEVELS-1:0] at_end;
    logic [NUM_LEVELS:0]   carry;

    // End test runs one bit wider so count+stride cannot wrap past max.
    always_comb begin
        logic [DATA_WIDTH:0] sum;
        sum        = '0;
        at_end     = '0;
        carry      = '0;
        carry[0]   = 1'b1;
        count_next = count_q;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            sum = {1'b0, count_q[i*DATA_WIDTH +: DATA_WIDTH]}
                + {1'b0, stride_q[i*DATA_WIDTH +: DATA_WIDTH]};
            at_end[i] = (sum > {1'b0, max_q[i*DATA_WIDTH +: DATA_WIDTH]})
                     || (stride_q[i*DATA_WIDTH +: DATA_WIDTH] == '0);
            carry[i+1] = carry[i] && at_end[i];
            if (carry[i]) begin
                count_next[i*DATA_WIDTH +: DATA_WIDTH] =
                    at_end[i] ? '0 : sum[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            count_q  <= '0;
            max_q    <= '0;
            stride_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        max_q    <= bus.cfg_max;
                        stride_q <= bus.cfg_stride;
                        count_q  <= '0;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // abort wins over a beat accepted in the same cycle
                    if (bus.abort) begin
                        count_q <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (valid_q && bus.out_ready) begin
                        if (carry[NUM_LEVELS]) begin
                            count_q <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            count_q <= count_next;
                        end
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    count_q <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
    assign bus.wrap      = carry[NUM_LEVELS:1];
    assign bus.last      = carry[NUM_LEVELS];
endmodule

// File: tb/tb_nested_loop_count.sv
// Self-checking bench for nested_loop_count: directed scenarios plus random
// configurations, compared against a mixed-radix model of the loop nest.
module tb_nested_loop_count;
    localparam int DW = 4;
    localparam int NL = 3;
    localparam int W  = DW * NL;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cur_beat;

    logic [W-1:0]  exp_count[$];
    logic [NL-1:0] exp_wrap[$];

    nested_loop_count_if #(.DATA_WIDTH(DW), .NUM_LEVELS(NL)) bus ();

    nested_loop_count #(.DATA_WIDTH(DW), .NUM_LEVELS(NL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s beat=%0d observed=%0h expected=%0h", tag, cur_beat, obs, exp);
        end
    endtask

    // Each level iterates over 0, s, 2s, ... <= max (just {0} when s==0);
    // beat k is the mixed-radix decomposition of k with level 0 fastest.
    task automatic build_model(input logic [W-1:0] mx, input logic [W-1:0] st);
        int n[NL];
        int total;
        exp_count.delete();
        exp_wrap.delete();
        total = 1;
        for (int i = 0; i < NL; i++) begin
            int m, s;
            m = int'(mx[i*DW +: DW]);
            s = int'(st[i*DW +: DW]);
            n[i] = (s == 0) ? 1 : (m / s + 1);
            total = total * n[i];
        end
        for (int k = 0; k < total; k++) begin
            logic [W-1:0]  c;
            logic [NL-1:0] w;
            int rem;
            bit inner_end;
            rem = k;
            inner_end = 1'b1;
            c = '0;
            w = '0;
            for (int i = 0; i < NL; i++) begin
                int idx;
                idx = rem % n[i];
                rem = rem / n[i];
                c[i*DW +: DW] = DW'(idx * int'(st[i*DW +: DW]));
                inner_end = inner_end && (idx == n[i] - 1);
                w[i] = inner_end;
            end
            exp_count.push_back(c);
            exp_wrap.push_back(w);
        end
    endtask

    task automatic check_idle(input string tag, input logic [NL-1:0] wexp);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_busy"},  32'(bus.busy),      32'd0);
        check({tag, "_done"},  32'(bus.done),      32'd0);
        check({tag, "_count"}, 32'(bus.count),     32'd0);
        check({tag, "_wrap"},  32'(bus.wrap),      32'(wexp));
        check({tag, "_last"},  32'(bus.last),      32'(wexp[NL-1]));
    endtask

    // rmode: 0 always ready, 1 ready pattern 1,0,0, 2 random ready.
    // Called and returns at a falling edge.
    task automatic run_seq(input logic [W-1:0] mx, input logic [W-1:0] st, input int rmode,
                           input int abort_beat, input int reset_beat, input bit noise);
        int k;
        int cyc;
        int limit;
        bit rdy;
        build_model(mx, st);
        limit = exp_count.size() * 4 + 50;
        bus.cfg_max    = mx;
        bus.cfg_stride = st;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < exp_count.size() && cyc < limit) begin
            cur_beat = k;
            check("valid", 32'(bus.out_valid), 32'd1);
            check("busy",  32'(bus.busy),      32'd1);
            check("done",  32'(bus.done),      32'd0);
            check("count", 32'(bus.count),     32'(exp_count[k]));
            check("wrap",  32'(bus.wrap),      32'(exp_wrap[k]));
            check("last",  32'(bus.last),      32'(exp_wrap[k][NL-1]));
            if (rmode == 0)      rdy = 1'b1;
            else if (rmode == 1) rdy = (cyc % 3 == 0);
            else                 rdy = ($urandom_range(0, 3) != 0);
            if (noise) begin
                bus.start      = ($urandom_range(0, 1) == 1);
                bus.cfg_max    = W'($urandom);
                bus.cfg_stride = W'($urandom);
            end
            if (k == abort_beat) begin
                bus.start = 1'b0;
                bus.out_ready = 1'b1;
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                check_idle("abort", exp_wrap[0]);
                @(negedge clk);
                check("abort_nodone", 32'(bus.done), 32'd0);
                return;
            end
            if (k == reset_beat) begin
                bus.start = 1'b0;
                bus.out_ready = 1'b1;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                build_model('0, '0);
                check_idle("midreset", exp_wrap[0]);
                @(negedge clk);
                check("midreset_nodone", 32'(bus.done), 32'd0);
                return;
            end
            bus.out_ready = rdy;
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        cur_beat = k;
        check("beats", 32'(k), 32'(exp_count.size()));
        check("end_done",  32'(bus.done),      32'd1);
        check("end_valid", 32'(bus.out_valid), 32'd0);
        check("end_busy",  32'(bus.busy),      32'd0);
        check("end_count", 32'(bus.count),     32'd0);
        bus.start = noise;
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_done",  32'(bus.done),      32'd0);
        check("idle_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("idle_valid2", 32'(bus.out_valid), 32'd0);
        check("idle_busy2",  32'(bus.busy),      32'd0);
    endtask

    initial begin
        logic [W-1:0] basic_max;
        logic [W-1:0] ones;
        logic [W-1:0] rmx;
        logic [W-1:0] rst_v;
        tests = 0;
        fails = 0;
        cur_beat = 0;
        basic_max = {4'd1, 4'd2, 4'd3};
        ones      = {4'd1, 4'd1, 4'd1};
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_max = '0;
        bus.cfg_stride = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        build_model('0, '0);
        check_idle("reset", exp_wrap[0]);
        check("basic_total", 32'(exp_count.size()), 32'd1);

        // basic nest: 24 beats
        run_seq(basic_max, ones, 0, -1, -1, 1'b0);
        build_model(basic_max, ones);
        check("model_basic_beats", 32'(exp_count.size()), 32'd24);

        // non-dividing stride: 0,3,6
        run_seq({4'd0, 4'd0, 4'd7}, {4'd1, 4'd1, 4'd3}, 0, -1, -1, 1'b0);

        // backpressure
        run_seq(basic_max, ones, 1, -1, -1, 1'b0);

        // abort with accepted beat at beat 5, then reset at beat 3
        run_seq(basic_max, ones, 0, 5, -1, 1'b0);
        run_seq(basic_max, ones, 0, -1, 3, 1'b0);

        // edge configs: 4-bit overflow and zero stride on L1
        run_seq({4'd0, 4'd0, 4'd15}, {4'd1, 4'd1, 4'd15}, 0, -1, -1, 1'b0);
        run_seq({4'd2, 4'd5, 4'd1}, {4'd1, 4'd0, 4'd1}, 2, -1, -1, 1'b0);

        // config isolation: cfg and start toggled during RUN and DONE
        run_seq(basic_max, ones, 2, -1, -1, 1'b1);

        // random configurations with random backpressure
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NL; i++) begin
                rmx[i*DW +: DW]   = DW'($urandom_range(0, 9));
                rst_v[i*DW +: DW] = DW'($urandom_range(0, 4));
            end
            run_seq(rmx, rst_v, 2, -1, -1, (r % 2) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nested_loop_count.md
Name: nested_loop_count

Overview:
Parametrised successor to the single-level loop counter. It cascades NUM_LEVELS counters into a nested-loop index generator with per-level max and stride, and a carry chain from inner to outer levels. A valid/ready handshake lets the downstream consumer stall the sequence, and a start/done frame wraps each full run. It sits in the memory controller, driving address/index generation for tile and channel loops.

Parameters:
DATA_WIDTH, 4, width of each level's count, max and stride
NUM_LEVELS, 3, number of nested levels; level 0 is innermost

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
abort  input  1  terminate the current run; returns to IDLE next cycle
cfg_max  input  NUM_LEVELS*DATA_WIDTH  per-level max; level i at bits [i*DATA_WIDTH +: DATA_WIDTH]
cfg_stride  input  NUM_LEVELS*DATA_WIDTH  per-level stride; same packing as cfg_max
out_ready  input  1  consumer accepts the current index tuple
out_valid  output  1  count holds a valid index tuple
count  output  NUM_LEVELS*DATA_WIDTH  current indices, packed as cfg_max
wrap  output  NUM_LEVELS  wrap[i]=1 when levels 0..i are all at their end on this beat
last  output  1  equals wrap[NUM_LEVELS-1]; final beat of the run
busy  output  1  high in RUN
done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (synchronous, active-high): state=IDLE; count=0; out_valid=0; busy=0; done=0; latched config=0. Reset has priority over every other input, including mid-run.
- States: IDLE, RUN, DONE.
- IDLE: when start=1, latch cfg_max and cfg_stride, clear count to 0, and enter RUN next cycle. cfg_* are ignored outside this cycle.
- RUN: out_valid=1 and busy=1. A beat is accepted when out_valid && out_ready.
  - With no beat, count holds.
  - start is ignored in RUN.
- Per-level end test, using latched values and computed at DATA_WIDTH+1 bits (no overflow):
  - at_end[i] = (count_i + stride_i > max_i), or stride_i==0.
  - A stride of 0 pins the level at 0 and makes it a single-iteration level.
- Carry chain: carry[0]=1; carry[i+1] = carry[i] && at_end[i].
- On an accepted beat, for each level i with carry[i]=1:
  - if at_end[i], count_i <= 0;
  - else count_i <= count_i + stride_i.
  - Levels with carry[i]=0 hold.
- Output flags: wrap[i] = carry[i] && at_end[i], combinational from the current count. last = wrap[NUM_LEVELS-1].
- End of run: an accepted beat with last=1 moves to DONE; count returns to 0.
- DONE: lasts exactly 1 cycle with done=1, out_valid=0, busy=0; then IDLE. A start during DONE is ignored.
- Beats per run: product over i of (floor(max_i/stride_i)+1), with a factor of 1 for any stride_i=0.
- max_i=0 gives a single-iteration level.
- No overshoot: count_i never exceeds max_i. This differs from the single-level counter, which stepped past max when the stride did not divide it.
- abort in RUN: next cycle state=IDLE, count=0, out_valid=0; done is not asserted. abort has priority over a simultaneous accepted beat. abort is ignored in IDLE and DONE.
- Latency: first valid beat 1 cycle after start; one index advance per accepted beat; no bubbles while out_ready=1.
- Outputs are registered except wrap and last, which are combinational from registered count and latched config.

Test Plan:
- Basic nest: DATA_WIDTH=4, NUM_LEVELS=3, max={1,2,3} (L2,L1,L0), stride all 1, out_ready=1, start pulse -> 24 beats; L0 runs 0..3, L1 increments on each L0 wrap, last on beat 24 at (1,2,3), done pulse the following cycle, then IDLE.
- Non-dividing stride: L0 max=7, stride=3, other levels max=0 -> L0 sequence 0,3,6 then wrap (never 9 or 7 overshoot); 3 beats, last on 6.
- Backpressure: basic nest with out_ready toggling 1,0,0,1,... -> count advances only on accepted beats, holds value and out_valid while stalled, and the sequence is identical to the first scenario.
- Abort and reset mid-run: abort asserted together with an accepted beat at beat 5 -> IDLE next cycle, count=0, no done. Restart, then reset at beat 3 -> all outputs at reset values next cycle.
- Edge config: DATA_WIDTH=4, L0 max=15, stride=15 -> 0,15 then wrap, with no 4-bit overflow. Zero stride on L1 -> L1 stays 0 and L2 advances on each L0 wrap.
- Config isolation: change cfg_max during RUN and assert start during RUN and DONE -> no effect on the current run; beat count matches the latched config.
